// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM duty meter: divider states,
// 7-segment digit patterns and scaling constants.
package pwm_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_DONE
  } div_state_t;

  localparam int DUTY_SCALE = 10;
  localparam int SEG_DP_BIT = 7;

  // Segment order g..a, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment decoder: 0-9 as digits, 10 as "F", anything else blank.
module seg7_decode
  import pwm_meter_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here via the default arm), otherwise synthesis infers a latch.
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = SEG_F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of a PWM input, detects stuck levels by
// timeout, and converts duty to tenths for a 7-segment display.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MAX_PERIOD = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck,
  output logic [3:0]       duty_tenths,
  output logic             duty_valid,
  output logic             busy,
  output logic [7:0]       seg
);

  localparam int REM_W = CNT_W + 4;
  // The timeout fires on the edge that would take per to MAX_PERIOD, so a
  // constant input reports exactly every MAX_PERIOD cycles.
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_PERIOD - 1);

  logic             s, s_d, rise;
  logic [CNT_W-1:0] per, hi;
  logic             armed, stuck_lvl;

  div_state_t       state;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] divisor;
  logic [3:0]       q;
  logic [6:0]       seg_next;

  assign rise = s & ~s_d;

  // Edge detector, period/high counters and stuck timeout.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    if (!rst_n) begin
      s          <= 1'b0;
      s_d        <= 1'b0;
      per        <= '0;
      hi         <= '0;
      armed      <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      stuck      <= 1'b0;
      stuck_lvl  <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      s          <= pwm_in;
      s_d        <= s;
      meas_valid <= 1'b0;
      if (rise) begin
        // A partial period seen while unarmed is discarded.
        if (armed) begin
          period_cnt <= per;
          high_cnt   <= hi;
          stuck      <= 1'b0;
          meas_valid <= 1'b1;
        end
        per   <= CNT_W'(1);
        hi    <= CNT_W'(1);
        armed <= 1'b1;
      end else if (per == TIMEOUT_AT) begin
        period_cnt <= '0;
        high_cnt   <= '0;
        stuck      <= 1'b1;
        stuck_lvl  <= s;
        meas_valid <= 1'b1;
        per        <= '0;
        hi         <= '0;
        armed      <= 1'b0;
      end else begin
        per <= per + CNT_W'(1);
        hi  <= hi + CNT_W'(s);
      end
    end
  end

  seg7_decode u_seg7_decode (
    .value (q),
    .seg   (seg_next)
  );

  // Restoring divider: high*10 / period by repeated subtraction. The divisor
  // is latched so raw outputs updating mid-division cannot corrupt it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rem         <= '0;
      divisor     <= '0;
      q           <= '0;
      busy        <= 1'b0;
      duty_tenths <= '0;
      duty_valid  <= 1'b0;
      seg         <= '0;
    end else begin
      duty_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (meas_valid) begin
            if (stuck) begin
              q     <= stuck_lvl ? 4'(DUTY_SCALE) : 4'd0;
              state <= ST_DONE;
            end else begin
              rem     <= REM_W'(high_cnt) * REM_W'(DUTY_SCALE);
              divisor <= period_cnt;
              q       <= '0;
              busy    <= 1'b1;
              state   <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          if (rem >= REM_W'(divisor)) begin
            rem <= rem - REM_W'(divisor);
            q   <= q + 4'd1;
          end else begin
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          duty_tenths     <= q;
          duty_valid      <= 1'b1;
          seg[6:0]        <= seg_next;
          seg[SEG_DP_BIT] <= stuck;
          state           <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: table of PWM patterns plus hand-written
// sequences for reset, stuck-low/high, dropped measurements and reset mid-division.
module tb_pwm_duty_meter;

  localparam int CNT_W      = 8;
  localparam int MAX_PERIOD = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             meas_valid, stuck, duty_valid, busy;
  logic [3:0]       duty_tenths;
  logic [7:0]       seg;

  pwm_duty_meter #(.CNT_W(CNT_W), .MAX_PERIOD(MAX_PERIOD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .high_cnt    (high_cnt),
    .period_cnt  (period_cnt),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .duty_tenths (duty_tenths),
    .duty_valid  (duty_valid),
    .busy        (busy),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int hi; int per; int stk; } meas_t;
  typedef struct { int cyc; int duty; int seg; } duty_t;
  typedef struct { int p; int h; int exp_hi; int exp_per; int exp_duty; int exp_seg; int exp_busy; } vec_t;

  meas_t meas_q[$];
  duty_t duty_q[$];
  int    cyc = 0;
  int    busy_run = 0;
  int    last_busy_len = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic meas_t mk_meas(int c, int h, int p, int s);
    meas_t m;
    m.cyc = c; m.hi = h; m.per = p; m.stk = s;
    return m;
  endfunction

  function automatic duty_t mk_duty(int c, int d, int s);
    duty_t d_r;
    d_r.cyc = c; d_r.duty = d; d_r.seg = s;
    return d_r;
  endfunction

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (meas_valid === 1'b1) meas_q.push_back(mk_meas(cyc, int'(high_cnt), int'(period_cnt), int'(stuck)));
    if (duty_valid === 1'b1) duty_q.push_back(mk_duty(cyc, int'(duty_tenths), int'(seg)));
    if (busy === 1'b1) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      last_busy_len <= busy_run;
      busy_run      <= 0;
    end
  end

  function automatic meas_t meas_at(int i);
    meas_t m = mk_meas(-1, -1, -1, -1);
    if (i >= 0 && i < meas_q.size()) m = meas_q[i];
    return m;
  endfunction

  function automatic duty_t duty_at(int i);
    duty_t d = mk_duty(-1, -1, -1);
    if (i >= 0 && i < duty_q.size()) d = duty_q[i];
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p);
    pwm_in = p;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_pwm(input int p, input int h, input int n);
    ph = ph % p;
    for (int i = 0; i < n; i++) begin
      step(ph < h);
      ph = (ph + 1) % p;
    end
  endtask

  task automatic clear_q();
    meas_q.delete();
    duty_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    meas_t m0, m1;
    duty_t d0;
    int    t0, bad, seen;

    vecs[0] = '{10, 5,  5, 10, 5, 8'h6D, 6};
    vecs[1] = '{10, 3,  3, 10, 3, 8'h4F, 4};
    vecs[2] = '{ 4, 3,  3,  4, 7, 8'h07, 8};
    vecs[3] = '{ 7, 2,  2,  7, 2, 8'h5B, 3};
    vecs[4] = '{20, 19, 19, 20, 9, 8'h6F, 10};
    vecs[5] = '{ 2, 1,  1,  2, 5, 8'h6D, 6};
    vecs[6] = '{16, 1,  1, 16, 0, 8'h3F, 1};

    // Reset held 3 cycles with the input toggling.
    rst_n = 1'b0;
    step(1'b1); step(1'b0); step(1'b1);
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_duty", duty_tenths, 0);
    check("rst_duty_valid", duty_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_seg", seg, 8'h00);

    // Stuck-low from reset: first timeout MAX_PERIOD cycles after release.
    clear_q();
    t0 = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) step(1'b0);
    m0 = meas_at(0);
    d0 = duty_at(0);
    check("first_timeout_cycle", m0.cyc - t0, MAX_PERIOD);
    check("first_timeout_stuck", m0.stk, 1);
    check("stuck_duty_latency", d0.cyc - m0.cyc, 2);
    check("stuck_lo_duty", d0.duty, 0);
    check("stuck_lo_seg", d0.seg, 8'hBF);

    // First edge after a timeout only arms.
    clear_q();
    ph = 0;
    run_pwm(10, 5, 10);
    check("arm_only_count", meas_q.size(), 0);
    run_pwm(10, 5, 10);
    m0 = meas_at(0);
    check("first_meas_count", meas_q.size(), 1);
    check("first_meas_high", m0.hi, 5);
    check("first_meas_period", m0.per, 10);
    check("first_meas_stuck", m0.stk, 0);
    run_pwm(10, 5, 10);
    m1 = meas_at(1);
    d0 = duty_at(0);
    check("meas_interval", m1.cyc - m0.cyc, 10);
    check("duty_latency", d0.cyc - m0.cyc, 8);
    check("first_duty", d0.duty, 5);
    check("first_seg", d0.seg, 8'h6D);

    // Table of steady PWM patterns.
    foreach (vecs[k]) begin
      clear_q();
      run_pwm(vecs[k].p, vecs[k].h, 8 * vecs[k].p + 40);
      m0 = meas_at(meas_q.size() - 1);
      d0 = duty_at(duty_q.size() - 1);
      check($sformatf("vec%0d_high", k), m0.hi, vecs[k].exp_hi);
      check($sformatf("vec%0d_period", k), m0.per, vecs[k].exp_per);
      check($sformatf("vec%0d_stuck", k), m0.stk, 0);
      check($sformatf("vec%0d_duty", k), d0.duty, vecs[k].exp_duty);
      check($sformatf("vec%0d_seg", k), d0.seg, vecs[k].exp_seg);
      check($sformatf("vec%0d_busy_len", k), last_busy_len, vecs[k].exp_busy);
    end

    // Constant low: timeouts every MAX_PERIOD cycles, counts zero.
    clear_q();
    for (int i = 0; i < 600; i++) step(1'b0);
    bad = 0;
    foreach (meas_q[i]) if (meas_q[i].stk != 1 || meas_q[i].hi != 0 || meas_q[i].per != 0) bad++;
    check("stuck_lo_enough", meas_q.size() >= 2, 1);
    check("stuck_lo_bad_events", bad, 0);
    check("stuck_lo_interval", meas_at(1).cyc - meas_at(0).cyc, MAX_PERIOD);
    check("stuck_lo_last_seg", duty_at(duty_q.size() - 1).seg, 8'hBF);

    // Constant high: first edge arms, then timeouts read as 10 / "F".
    clear_q();
    for (int i = 0; i < 600; i++) step(1'b1);
    bad = 0;
    foreach (meas_q[i]) if (meas_q[i].stk != 1) bad++;
    check("stuck_hi_enough", meas_q.size() >= 2, 1);
    check("stuck_hi_real_meas", bad, 0);
    check("stuck_hi_interval", meas_at(1).cyc - meas_at(0).cyc, MAX_PERIOD);
    check("stuck_hi_duty", duty_tenths, 10);
    check("stuck_hi_seg", seg, 8'hF1);

    // Fast edges: measurements arriving mid-division are dropped cleanly.
    clear_q();
    ph = 0;
    run_pwm(4, 3, 60);
    m0 = meas_at(0);
    check("recover_stuck", m0.stk, 0);
    check("recover_high", m0.hi, 3);
    check("recover_period", m0.per, 4);
    bad = 0;
    foreach (duty_q[i]) if (duty_q[i].duty != 7 || duty_q[i].seg != 8'h07) bad++;
    check("fast_duty_enough", duty_q.size() >= 3, 1);
    check("fast_duty_bad", bad, 0);
    clear_q();
    run_pwm(10, 5, 60);
    check("slow_again_stuck", meas_at(meas_q.size() - 1).stk, 0);
    check("slow_again_seg", seg, 8'h6D);

    // Reset asserted for one cycle while the divider is busy.
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      run_pwm(10, 5, 1);
      if (busy === 1'b1) seen = 1;
    end
    check("busy_seen", seen, 1);
    rst_n = 1'b0;
    step(1'b0);
    check("midrst_busy", busy, 0);
    check("midrst_seg", seg, 8'h00);
    check("midrst_duty", duty_tenths, 0);
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 9; i++) step(1'b0);
    check("midrst_no_duty_valid", duty_q.size(), 0);
    ph = 0;
    run_pwm(10, 5, 10);
    check("midrst_arm_only", meas_q.size(), 0);
    run_pwm(10, 5, 10);
    m0 = meas_at(0);
    check("midrst_meas_count", meas_q.size(), 1);
    check("midrst_meas_high", m0.hi, 5);
    check("midrst_meas_period", m0.per, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
